// File: rtl/mem_bus_pkg.sv
// Shared definitions for the 64-bit cache/memory bus.
package mem_bus_pkg;

  localparam int unsigned MEM_TAG_W  = 4;
  localparam int unsigned MEM_DATA_W = 64;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_t;

  // One in-flight load as it travels down the delay line.
  typedef struct packed {
    logic                  valid;
    logic [MEM_TAG_W-1:0]  tag;
    logic [MEM_DATA_W-1:0] data;
  } mem_pend_t;

  localparam logic [MEM_TAG_W-1:0] TAG_MAX = '1;

  // Round-robin tag issue over 1..15; tag 0 means "no transaction".
  function automatic logic [MEM_TAG_W-1:0] tag_advance(input logic [MEM_TAG_W-1:0] t);
    return (t == TAG_MAX) ? MEM_TAG_W'(1) : t + MEM_TAG_W'(1);
  endfunction

endpackage

// File: rtl/mem_delay_line.sv
// Fixed-depth shift register carrying load completions; no stalls.
module mem_delay_line
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic      clock,
  input  logic      clear_n,
  input  mem_pend_t entry_in,
  output mem_pend_t entry_out
);

  mem_pend_t stages [DEPTH];

  // Shift every cycle; synchronous clear drops everything in flight.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= entry_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign entry_out = stages[DEPTH-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: backing store, tag issue and fixed-latency load return.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [63:0]           mem_addr_in,
  input  logic [MEM_DATA_W-1:0] mem_data_in,
  input  logic [1:0]            mem_command_in,
  output logic [MEM_TAG_W-1:0]  mem_response_out,
  output logic [MEM_TAG_W-1:0]  mem_tag_out,
  output logic [MEM_DATA_W-1:0] mem_data_out
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  logic [MEM_DATA_W-1:0] mem [MEM_WORDS];
  logic [IDX_W-1:0]      idx;
  logic [MEM_TAG_W-1:0]  next_tag;
  logic [MEM_TAG_W-1:0]  outstanding;
  logic                  reset_q;
  logic                  in_range;
  logic                  is_load;
  logic                  is_store;
  logic                  accept;
  logic                  load_accept;
  logic                  done;
  logic                  addr_unused;
  mem_pend_t             pend_in;
  mem_pend_t             pend_out;

  // Byte offset within a word has no meaning on this bus.
  assign addr_unused = ^mem_addr_in[2:0];
  assign idx         = mem_addr_in[3 +: IDX_W];
  assign in_range    = mem_addr_in[63:3] < 61'(MEM_WORDS);
  assign done        = pend_out.valid;

  // Acceptance, same-cycle response and the stage-0 entry for an accepted load.
  always_comb begin
    is_load          = (mem_command_in == BUS_LOAD);
    is_store         = (mem_command_in == BUS_STORE);
    // Hold off for the cycle after reset so every output reads 0 there too.
    accept           = (is_load || is_store) && in_range && (outstanding < TAG_MAX)
                       && reset_n && !reset_q;
    load_accept      = accept && is_load;
    mem_response_out = accept ? next_tag : '0;
    pend_in          = '0;
    if (load_accept) begin
      pend_in.valid = 1'b1;
      pend_in.tag   = next_tag;
      pend_in.data  = mem[idx];
    end
  end

  // Backing store write; deliberately untouched by reset.
  always_ff @(posedge clock) begin
    if (accept && is_store) begin
      mem[idx] <= mem_data_in;
    end
  end

  // Tag counter and outstanding-load count.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      next_tag    <= MEM_TAG_W'(1);
      outstanding <= '0;
      reset_q     <= 1'b1;
    end else begin
      reset_q <= 1'b0;
      if (accept) begin
        next_tag <= tag_advance(next_tag);
      end
      if (load_accept && !done) begin
        outstanding <= outstanding + MEM_TAG_W'(1);
      end else if (!load_accept && done) begin
        outstanding <= outstanding - MEM_TAG_W'(1);
      end
    end
  end

  mem_delay_line #(
    .DEPTH (LATENCY)
  ) u_delay (
    .clock     (clock),
    .clear_n   (reset_n),
    .entry_in  (pend_in),
    .entry_out (pend_out)
  );

  // Registered completion, forced to 0 while reset is asserted.
  always_comb begin
    mem_tag_out  = '0;
    mem_data_out = '0;
    if (reset_n && pend_out.valid) begin
      mem_tag_out  = pend_out.tag;
      mem_data_out = pend_out.data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=8 instance plus a LATENCY=20 instance.
module tb_mem_responder;
  import mem_bus_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [63:0] a_addr, a_data, a_dout;
  logic [1:0]  a_cmd;
  logic [3:0]  a_resp, a_tag;
  logic [63:0] b_addr, b_data, b_dout;
  logic [1:0]  b_cmd;
  logic [3:0]  b_resp, b_tag;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] BEEF = 64'hDEAD_BEEF_0000_0001;

  always #5 clock = ~clock;

  mem_responder #(.MEM_WORDS(4096), .LATENCY(8)) dut_a (
    .clock(clock), .reset_n(reset_n), .mem_addr_in(a_addr), .mem_data_in(a_data),
    .mem_command_in(a_cmd), .mem_response_out(a_resp), .mem_tag_out(a_tag),
    .mem_data_out(a_dout));

  mem_responder #(.MEM_WORDS(4096), .LATENCY(20)) dut_b (
    .clock(clock), .reset_n(reset_n), .mem_addr_in(b_addr), .mem_data_in(b_data),
    .mem_command_in(b_cmd), .mem_response_out(b_resp), .mem_tag_out(b_tag),
    .mem_data_out(b_dout));

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] cmd, input logic [63:0] addr, input logic [63:0] data);
    a_cmd  = cmd;
    a_addr = addr;
    a_data = data;
  endtask

  // One cycle with reset_n low, then the cycle after it; a load is offered throughout.
  task automatic do_reset();
    cyc();
    reset_n = 1'b0;
    drive_a(BUS_LOAD, 64'h0, 64'h0);
    b_cmd = BUS_NONE;
    @(negedge clock);
    check("rst_resp", 64'(a_resp), 64'h0);
    check("rst_tag", 64'(a_tag), 64'h0);
    cyc();
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_resp", 64'(a_resp), 64'h0);
    check("post_rst_tag", 64'(a_tag), 64'h0);
    check("post_rst_data", a_dout, 64'h0);
    cyc();
    drive_a(BUS_NONE, 64'h0, 64'h0);
  endtask

  initial begin
    logic [15:0] busy;
    logic [3:0]  exp_tag;
    logic [3:0]  exp_resp;

    reset_n = 1'b0;
    drive_a(BUS_NONE, 64'h0, 64'h0);
    b_cmd = BUS_NONE; b_addr = 64'h0; b_data = 64'h0;

    // Store then load of the same word.
    do_reset();
    cyc();
    drive_a(BUS_STORE, 64'h100, BEEF);
    @(negedge clock);
    check("t1_store_resp", 64'(a_resp), 64'd1);
    cyc();
    drive_a(BUS_LOAD, 64'h100, 64'h0);
    @(negedge clock);
    check("t1_load_resp", 64'(a_resp), 64'd2);
    check("t1_tag_k0", 64'(a_tag), 64'h0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      drive_a(BUS_NONE, 64'h0, 64'h0);
      @(negedge clock);
      check("t1_tag", 64'(a_tag), (k == 8) ? 64'd2 : 64'd0);
      check("t1_data", a_dout, (k == 8) ? BEEF : 64'd0);
    end

    // Preload three words, reset (store retained), then back-to-back loads.
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive_a(BUS_STORE, 64'(8 * i), 64'(i + 1));
      @(negedge clock);
      check("t2_store_resp", 64'(a_resp), 64'(i + 3));
    end
    do_reset();
    for (int k = 0; k <= 11; k++) begin
      cyc();
      if (k < 3) drive_a(BUS_LOAD, 64'(8 * k), 64'h0);
      else       drive_a(BUS_NONE, 64'h0, 64'h0);
      @(negedge clock);
      if (k < 3) check("t2_resp", 64'(a_resp), 64'(k + 1));
      check("t2_tag", 64'(a_tag), (k >= 8 && k <= 10) ? 64'(k - 7) : 64'd0);
      check("t2_data", a_dout, (k >= 8 && k <= 10) ? 64'(k - 7) : 64'd0);
    end

    // Twenty accepted stores: tags wrap 15 -> 1, never 0.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc();
      drive_a(BUS_STORE, 64'h200 + 64'(8 * i), 64'h1000 + 64'(i));
      @(negedge clock);
      check("t3_resp", 64'(a_resp), 64'((i % 15) + 1));
    end

    // Rejected commands leave next_tag alone and never complete.
    cyc();
    drive_a(BUS_LOAD, 64'h8000, 64'h0);
    @(negedge clock);
    check("t4_oor_resp", 64'(a_resp), 64'd0);
    cyc();
    drive_a(BUS_LOAD, 64'h8000_0000_0000_0100, 64'h0);
    @(negedge clock);
    check("t4_oor_hi_resp", 64'(a_resp), 64'd0);
    cyc();
    drive_a(2'b11, 64'h200, 64'h0);
    @(negedge clock);
    check("t4_cmd11_resp", 64'(a_resp), 64'd0);
    cyc();
    drive_a(BUS_LOAD, 64'h200, 64'h0);
    @(negedge clock);
    check("t4_load_resp", 64'(a_resp), 64'd6);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      drive_a(BUS_NONE, 64'h0, 64'h0);
      @(negedge clock);
      check("t4_tag", 64'(a_tag), (k == 8) ? 64'd6 : 64'd0);
      check("t4_data", a_dout, (k == 8) ? 64'h1000 : 64'd0);
    end

    // Reset with a load in flight: it is dropped, tags restart, memory kept.
    do_reset();
    cyc();
    drive_a(BUS_LOAD, 64'h100, 64'h0);
    @(negedge clock);
    check("t5_resp", 64'(a_resp), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      drive_a(BUS_NONE, 64'h0, 64'h0);
      @(negedge clock);
      check("t5_pre_tag", 64'(a_tag), 64'd0);
    end
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cyc();
      @(negedge clock);
      check("t5_dropped_tag", 64'(a_tag), 64'd0);
    end
    cyc();
    drive_a(BUS_LOAD, 64'h100, 64'h0);
    @(negedge clock);
    check("t5_reload_resp", 64'(a_resp), 64'd1);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      drive_a(BUS_NONE, 64'h0, 64'h0);
      @(negedge clock);
      check("t5_tag", 64'(a_tag), (k == 8) ? 64'd1 : 64'd0);
      check("t5_data", a_dout, (k == 8) ? BEEF : 64'd0);
    end

    // LATENCY=20: fill all 15 tags, stall, then reuse tag 1 after it completes.
    cyc();
    b_cmd = BUS_STORE; b_addr = 64'h0; b_data = 64'hB0;
    @(negedge clock);
    check("t6_store_resp", 64'(b_resp), 64'd1);
    do_reset();
    busy = '0;
    for (int c = 0; c <= 45; c++) begin
      cyc();
      b_cmd = (c <= 21) ? BUS_LOAD : BUS_NONE;
      b_addr = 64'h0;
      @(negedge clock);
      if (c < 15)       exp_resp = 4'(c + 1);
      else if (c == 21) exp_resp = 4'd1;
      else              exp_resp = 4'd0;
      if (c >= 20 && c <= 34) exp_tag = 4'(c - 19);
      else if (c == 41)       exp_tag = 4'd1;
      else                    exp_tag = 4'd0;
      if (c <= 21) check("t6_resp", 64'(b_resp), 64'(exp_resp));
      check("t6_tag", 64'(b_tag), 64'(exp_tag));
      check("t6_data", b_dout, (exp_tag != 4'd0) ? 64'hB0 : 64'd0);
      if (b_tag != 4'd0) begin
        check("t6_complete_busy", 64'(busy[b_tag]), 64'd1);
        busy[b_tag] = 1'b0;
      end
      if (b_resp != 4'd0) begin
        check("t6_issue_free", 64'(busy[b_resp]), 64'd0);
        busy[b_resp] = 1'b1;
      end
    end
    check("t6_all_drained", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable memory-side responder for the shared 64-bit cache/memory bus; it sits at the far end of the Icache/Dcache arbiter.
- Accepts one BUS_LOAD or BUS_STORE per cycle and issues a 4-bit transaction tag in the same cycle.
- Returns load data with that tag a fixed LATENCY cycles later.
- Replaces the behavioural memory model in simulation and serves as the FPGA-side memory controller stub.

Parameters:
- MEM_WORDS, 4096, number of 64-bit words in the backing store; power of two.
- LATENCY, 8, cycles from load acceptance to data return; legal range 1..32.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- mem_addr_in  in  64  byte address; word index = addr[3 +: $clog2(MEM_WORDS)]; addr[2:0] ignored.
- mem_data_in  in  64  store data.
- mem_command_in  in  2  BUS_NONE / BUS_LOAD / BUS_STORE.
- mem_response_out  out  4  same-cycle acceptance tag; 0 = not accepted.
- mem_tag_out  out  4  tag of the load completing this cycle; 0 = none.
- mem_data_out  out  64  load data, valid when mem_tag_out != 0; 0 otherwise.

Behaviour:
- Reset (reset_n low at a clock edge):
  - Delay line cleared.
  - next_tag = 1; outstanding = 0.
  - All outputs 0 while reset_n is low and in the cycle after it.
  - Backing store is NOT cleared.
  - Loads in flight at reset are dropped and never returned.
- Acceptance (combinational):
  - Accept when command != BUS_NONE, address is in range (addr[63:3] < MEM_WORDS), and outstanding < 15.
  - On accept, mem_response_out = next_tag; otherwise mem_response_out = 0.
  - Out-of-range address or full tag space: response 0, no state change; the requester retries.
- Tag allocation:
  - next_tag advances only on an accepted command (load or store), wrapping 15 -> 1.
  - Tag 0 is never issued.
- Store:
  - mem[idx] <= mem_data_in at the accepting edge.
  - No completion is returned; the tag is consumed but never occupies the outstanding count.
- Load:
  - mem[idx] is read at the accepting edge; the value includes all stores accepted in earlier cycles.
  - The delay-line stage-0 entry {valid, tag, data} is written.
  - outstanding increments.
- Delay line:
  - LATENCY stages, shifting every cycle; no stalls (the requester cannot backpressure).
  - The last stage drives mem_tag_out / mem_data_out, registered.
  - A load accepted at edge t completes in the cycle following edge t+LATENCY-1, i.e. LATENCY cycles after the request cycle.
- Outstanding count:
  - Decrements when the last-stage entry is valid.
  - Acceptance and completion in the same cycle leave the count unchanged.
  - Because at most one load is accepted per cycle, at most one completes per cycle; no completion collisions.
- Full condition: only reachable when LATENCY >= 15. With 15 loads outstanding, new commands (including stores) get response 0 until a completion frees a slot. The check uses the pre-edge count, so a completion in the same cycle does not make room that cycle.
- Tag uniqueness: a tag is never reissued while a load holding it is outstanding. This is guaranteed by the 15-entry limit plus round-robin issue, which the bench must check.
- Undefined command encoding 2'b11: treated as BUS_NONE.

Decomposition:
- Shared package mem_bus_pkg:
  - BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2.
  - MEM_TAG_W = 4, MEM_DATA_W = 64.
  - Struct mem_pend_t {valid, tag, data} for delay-line entries.
- One sub-module, mem_delay_line (parameterized depth, mem_pend_t payload, synchronous active-low clear).
- Backing store, tag counter and acceptance logic stay in mem_responder.

Test Plan:
- Store 64'hDEAD_BEEF_0000_0001 to 0x100 in cycle 2, then load 0x100 in cycle 3 -> response 1 then 2; in cycle 3+LATENCY, tag_out = 2 and data_out = 64'hDEAD_BEEF_0000_0001; tag_out = 0 in all other cycles.
- Back-to-back loads of 0x0, 0x8, 0x10 (preloaded 1, 2, 3) in consecutive cycles -> responses 1, 2, 3; data 1, 2, 3 returned in three consecutive cycles starting LATENCY cycles after the first request.
- 20 consecutive accepted commands -> response sequence 1..15, 1..5; tag 0 never issued.
- LATENCY = 20, 16 consecutive loads -> first 15 accepted, 16th gets response 0. The first load accepted after tag 1 completes receives tag 1.
- Load at address MEM_WORDS*8 -> response 0; next_tag unchanged; no completion.
- Load accepted, reset_n low for one cycle at LATENCY/2 -> no completion ever appears; after reset the next accepted load gets response 1; memory contents retained.
